a5_stream_ctrl: RTL

- Control and datapath stage wrapped around the A5/1 keystream core.
- Upstream side: accepts a 64-bit session key and a 22-bit frame number. Pulses the core reset, then serialises key then frame onto the core's key_in over exactly 86 cycles.
- Downstream side: once the core reports ready, serialises plaintext bytes onto bit_in one bit per clock and packs the core's combinational bit_out into ciphertext bytes.
- The core steps every clock, so the run phase is free-running; starvation is flagged, never stalled.

---
 rtl/a5_stream_ctrl.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/a5_stream_ctrl.sv
// a5_stream_ctrl: control and datapath stage around an A5/1 keystream core.
//
// Session sequence: IDLE -> CRST (one-cycle core reset) -> KEY (64 key bits,
// LSB first) -> FRAME (22 frame bits, LSB first) -> WARM (wait for
// cipher_ready) -> RUN (free-running byte encryption).
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start, abort        session request (IDLE only) / return to IDLE
//   key, frame          session key and frame number, sampled on start
//   busy                high outside IDLE
//   cipher_rst          core reset pulse
//   cipher_key_in       serial key/frame load into the core
//   cipher_bit_in       serial plaintext into the core
//   cipher_bit_out      core output (keystream XOR bit_in)
//   cipher_ready        core warm-up complete
//   in_data/in_valid/in_ready   plaintext byte handshake
//   out_data/out_valid  ciphertext byte, one-cycle strobe
//   underrun, timeout   sticky error flags
//
// All outputs are flops; their next values are derived from the next state
// so each output lines up with the state it describes.
module a5_stream_ctrl #(
  parameter int unsigned KEY_W    = 64,
  parameter int unsigned FRAME_W  = 22,
  parameter int unsigned WARM_MAX = 127
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [KEY_W-1:0]   key,
  input  logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               cipher_rst,
  output logic               cipher_key_in,
  output logic               cipher_bit_in,
  input  logic               cipher_bit_out,
  input  logic               cipher_ready,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  output logic               underrun,
  output logic               timeout
);

  localparam int unsigned CNT_W = $clog2(KEY_W + FRAME_W + WARM_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CRST,
    ST_KEY,
    ST_FRAME,
    ST_WARM,
    ST_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [2:0]         bitcnt_q, bitcnt_d;
  logic [7:0]         sreg_q, sreg_d;
  logic [7:0]         pack_q, pack_d;
  logic               hv_q, hv_d;     // sreg holds a byte
  logic               act_q, act_d;   // current slot is transmitting sreg
  logic               busy_q, busy_d;
  logic               crst_q, crst_d;
  logic               key_in_q, key_in_d;
  logic               bit_in_q, bit_in_d;
  logic               in_ready_q, in_ready_d;
  logic [7:0]         out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               underrun_q, underrun_d;
  logic               timeout_q, timeout_d;
  logic               accept;

  assign accept = in_ready_q & in_valid;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_d       = key_q;
    frame_d     = frame_q;
    bitcnt_d    = bitcnt_q;
    sreg_d      = sreg_q;
    pack_d      = pack_q;
    hv_d        = hv_q;
    act_d       = act_q;
    key_in_d    = 1'b0;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underrun_d  = underrun_q;
    timeout_d   = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d      = key;
          frame_d    = frame;
          underrun_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = ST_CRST;
        end
      end
      ST_CRST: begin
        // key_q/frame_q act as shift registers; the LSB is the bit on the wire
        key_in_d = key_q[0];
        key_d    = key_q >> 1;
        cnt_d    = '0;
        state_d  = ST_KEY;
      end
      ST_KEY: begin
        if (cnt_q == CNT_W'(KEY_W - 1)) begin
          key_in_d = frame_q[0];
          frame_d  = frame_q >> 1;
          cnt_d    = '0;
          state_d  = ST_FRAME;
        end else begin
          key_in_d = key_q[0];
          key_d    = key_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_FRAME: begin
        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_WARM;
        end else begin
          key_in_d = frame_q[0];
          frame_d  = frame_q >> 1;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      ST_WARM: begin
        if (cipher_ready) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          hv_d     = 1'b0;
          act_d    = 1'b0;
          state_d  = ST_RUN;
        end else if (cnt_q == CNT_W'(WARM_MAX - 1)) begin
          cnt_d     = '0;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        bitcnt_d = bitcnt_q + 1'b1;
        if (act_q) begin
          pack_d[bitcnt_q] = cipher_bit_out;
        end
        if (bitcnt_q == 3'd7) begin
          if (act_q) begin
            out_data_d  = {cipher_bit_out, pack_q[6:0]};
            out_valid_d = 1'b1;
          end
          if (accept) begin
            sreg_d = in_data;
            hv_d   = 1'b1;
            act_d  = 1'b1;
          end else if (hv_q && !act_q) begin
            // byte taken mid-slot waits for this boundary to keep framing
            act_d = 1'b1;
          end else begin
            hv_d       = 1'b0;
            act_d      = 1'b0;
            underrun_d = 1'b1;
          end
        end else if (accept) begin
          sreg_d = in_data;
          hv_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // abort wins over everything; the sticky flags survive it
    if (abort) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      key_d      = key_q;
      frame_d    = frame_q;
      bitcnt_d   = '0;
      pack_d     = '0;
      hv_d       = 1'b0;
      act_d      = 1'b0;
      key_in_d   = 1'b0;
      out_data_d = '0;
      out_valid_d = 1'b0;
      underrun_d = underrun_q;
      timeout_d  = timeout_q;
    end

    busy_d     = (state_d != ST_IDLE);
    crst_d     = (state_d == ST_CRST);
    in_ready_d = (state_d == ST_RUN) && (!hv_d || (bitcnt_d == 3'd7 && act_d));
    bit_in_d   = (state_d == ST_RUN) && act_d && sreg_d[bitcnt_d];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      key_q       <= '0;
      frame_q     <= '0;
      bitcnt_q    <= '0;
      sreg_q      <= '0;
      pack_q      <= '0;
      hv_q        <= 1'b0;
      act_q       <= 1'b0;
      busy_q      <= 1'b0;
      crst_q      <= 1'b0;
      key_in_q    <= 1'b0;
      bit_in_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_q       <= key_d;
      frame_q     <= frame_d;
      bitcnt_q    <= bitcnt_d;
      sreg_q      <= sreg_d;
      pack_q      <= pack_d;
      hv_q        <= hv_d;
      act_q       <= act_d;
      busy_q      <= busy_d;
      crst_q      <= crst_d;
      key_in_q    <= key_in_d;
      bit_in_q    <= bit_in_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign busy          = busy_q;
  assign cipher_rst    = crst_q;
  assign cipher_key_in = key_in_q;
  assign cipher_bit_in = bit_in_q;
  assign in_ready      = in_ready_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign underrun      = underrun_q;
  assign timeout       = timeout_q;

endmodule
